reg_exec_unit: RTL



---
 rtl/reg_exec_pkg.sv | 33 +++
 rtl/reg_exec_unit_alu_core.sv | 95 +++++++++
 rtl/reg_exec_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reg_exec_pkg.sv
// Shared types for the register-file execute stage: opcodes, FSM states and
// the bit positions of the {Z,N,C,V} flags register.
package reg_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_ADC = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_CMP = 4'h6,
    OP_MOV = 4'h7,
    OP_INC = 4'h8,
    OP_DEC = 4'h9,
    OP_SHR = 4'hA,
    OP_SHL = 4'hB,
    OP_NOT = 4'hC
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/reg_exec_unit_alu_core.sv
// Purely combinational ALU for the execute stage: result, Z/N/C/V and the
// write-back / illegal classification of the opcode.
module alu_core
  import reg_exec_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic                 c_in,
  output logic [WORD_SIZE-1:0] result,
  output logic                 z,
  output logic                 n,
  output logic                 c,
  output logic                 v,
  output logic                 is_illegal,
  output logic                 writes_back
);

  localparam int MSB = WORD_SIZE - 1;

  logic [WORD_SIZE-1:0] one;
  logic [WORD_SIZE-1:0] rhs;
  logic                 carry_in;
  logic [WORD_SIZE:0]   add_sum;
  logic [WORD_SIZE:0]   sub_diff;
  logic                 add_v;
  logic                 sub_v;

  assign one = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  // INC/DEC reuse the shared adder/subtractor with a constant right operand.
  always_comb begin
    rhs      = b;
    carry_in = 1'b0;
    case (op)
      OP_ADC:         carry_in = c_in;
      OP_INC, OP_DEC: rhs      = one;
      default:        ;
    endcase
  end

  assign add_sum  = {1'b0, a} + {1'b0, rhs} + {{WORD_SIZE{1'b0}}, carry_in};
  assign sub_diff = {1'b0, a} - {1'b0, rhs};
  assign add_v    = (a[MSB] == rhs[MSB]) && (add_sum[MSB] != a[MSB]);
  assign sub_v    = (a[MSB] != rhs[MSB]) && (sub_diff[MSB] != a[MSB]);

  always_comb begin
    result      = '0;
    c           = 1'b0;
    v           = 1'b0;
    is_illegal  = 1'b0;
    writes_back = 1'b1;
    case (op)
      OP_ADD, OP_ADC, OP_INC: begin
        result = add_sum[MSB:0];
        c      = add_sum[WORD_SIZE];
        v      = add_v;
      end
      OP_SUB, OP_DEC: begin
        result = sub_diff[MSB:0];
        c      = sub_diff[WORD_SIZE];
        v      = sub_v;
      end
      OP_CMP: begin
        result      = sub_diff[MSB:0];
        c           = sub_diff[WORD_SIZE];
        v           = sub_v;
        writes_back = 1'b0;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_MOV: result = b;
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        c      = a[0];
      end
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        c      = a[MSB];
      end
      default: begin
        is_illegal  = 1'b1;
        writes_back = 1'b0;
      end
    endcase
  end

  assign z = (result == '0);
  assign n = result[MSB];

endmodule

// File: rtl/reg_exec_unit.sv
// Four-cycle execute stage: latches one (op, Rx, Ry) instruction, reads the
// register file, computes through alu_core, writes back and updates flags.
module reg_exec_unit
  import reg_exec_pkg::*;
#(
  parameter  int WORD_SIZE  = 16,
  parameter  int COUNT      = 32,
  localparam int COUNT_BITS = $clog2(COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE, and upstream must
  // hold in_valid and the instruction fields stable until that edge.
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [COUNT_BITS-1:0] in_rx,
  input  logic [COUNT_BITS-1:0] in_ry,
  output logic [COUNT_BITS-1:0] rf_idx_a,
  output logic [COUNT_BITS-1:0] rf_idx_b,
  input  logic [WORD_SIZE-1:0]  rf_data_a,
  input  logic [WORD_SIZE-1:0]  rf_data_b,
  output logic [COUNT_BITS-1:0] rf_idx_write,
  output logic [WORD_SIZE-1:0]  rf_data_write,
  output logic                  rf_en_write,
  output logic [3:0]            flags,
  output logic                  done,
  output logic                  illegal
);

  state_e                state;
  logic [3:0]            op_q;
  logic [COUNT_BITS-1:0] rx_q;
  logic [COUNT_BITS-1:0] ry_q;
  logic [WORD_SIZE-1:0]  op_a;
  logic [WORD_SIZE-1:0]  op_b;
  logic [WORD_SIZE-1:0]  result_q;
  logic [3:0]            next_flags_q;

  logic [WORD_SIZE-1:0]  alu_result;
  logic                  alu_z;
  logic                  alu_n;
  logic                  alu_c;
  logic                  alu_v;
  logic                  alu_illegal;
  logic                  alu_writes_back;
  logic                  keeps_flags;
  logic [3:0]            alu_flags;

  alu_core #(
    .WORD_SIZE (WORD_SIZE)
  ) u_alu (
    .op          (op_q),
    .a           (op_a),
    .b           (op_b),
    .c_in        (flags[FLAG_C]),
    .result      (alu_result),
    .z           (alu_z),
    .n           (alu_n),
    .c           (alu_c),
    .v           (alu_v),
    .is_illegal  (alu_illegal),
    .writes_back (alu_writes_back)
  );

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  assign keeps_flags   = (op_q == OP_MOV) || alu_illegal;
  assign rf_idx_a      = rx_q;
  assign rf_idx_b      = ry_q;
  assign rf_idx_write  = rx_q;
  assign rf_data_write = result_q;

  // WRITE-cycle strobes are set on the EXEC->WRITE edge so they are clean
  // registered pulses; flags commit on the edge leaving WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result_q     <= '0;
      next_flags_q <= '0;
      flags        <= '0;
      rf_en_write  <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= in_op;
            rx_q     <= in_rx;
            ry_q     <= in_ry;
            in_ready <= 1'b0;
            state    <= READ;
          end
        end
        READ: begin
          op_a  <= rf_data_a;
          op_b  <= rf_data_b;
          state <= EXEC;
        end
        EXEC: begin
          result_q     <= alu_result;
          next_flags_q <= keeps_flags ? flags : alu_flags;
          rf_en_write  <= alu_writes_back;
          done         <= 1'b1;
          illegal      <= alu_illegal;
          state        <= WRITE;
        end
        WRITE: begin
          flags       <= next_flags_q;
          rf_en_write <= 1'b0;
          done        <= 1'b0;
          illegal     <= 1'b0;
          in_ready    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
